instruction_fetch: RTL and testbench
====================================

// Module: instruction_fetch
// PURPOSE
// - Fetch stage upstream of the single-cycle decode/execute core. Replaces the direct pc -> instruction_memory path.
// - Issues in-order word requests to a variable-latency instruction memory using a valid/ready request and a valid-only response.
// - Buffers up to DEPTH fetched words, each tagged with its PC, and presents them to decode with a valid/ready handshake.
// - Handles taken-branch/jump redirects by flushing the buffer and discarding in-flight responses.
// PARAMETERS
// - RESET_PC  32'h0000_0000  first fetch address after reset
// - DEPTH     2              buffer entries; power of 2, >= 2; also the cap on in-flight requests
// PORTS
// - clk              in   1   clock, rising edge
// - reset            in   1   synchronous, active-high
// - imem_req_valid   out  1   request valid
// - imem_req_ready   in   1   memory accepts request
// - imem_req_addr    out  32  word address, bits [1:0] always 0
// - imem_resp_valid  in   1   response valid; one per accepted request, in order, >= 1 cycle after acceptance
// - imem_resp_data   in   32  instruction word
// - redirect_valid   in   1   execute requests a PC change
// - redirect_pc      in   32  new fetch PC
// - instr_valid      out  1   buffer head valid to decode
// - instr_ready      in   1   decode consumes head
// - instr            out  32  head instruction
// - instr_pc         out  32  PC of head instruction
// BEHAVIOUR
// - Reset (sync, highest priority over every other event):
//   - fetch_pc = RESET_PC; occupancy = 0; outstanding = 0; drop = 0.
//   - Outputs: imem_req_valid=0, instr_valid=0, instr=0, instr_pc=0.
//   - First request is issued in the first cycle with reset low.
// - Request issue:
//   - imem_req_valid = !redirect_valid && (outstanding + occupancy < DEPTH).
//   - Counts are registered; there is no same-cycle bypass from a pop.
//   - Once asserted, imem_req_addr is held stable until accepted. Only redirect or reset withdraws a request.
//   - On accept (valid & ready): fetch_pc += 4 (0xFFFF_FFFC wraps to 0); outstanding++.
// - Response:
//   - If drop > 0: discard the response; drop--; outstanding--.
//   - Otherwise: push {resp_pc, data} into the buffer; resp_pc += 4; outstanding--.
//   - resp_pc tracks the address of the oldest live in-flight request.
// - Output:
//   - instr/instr_pc come from registered buffer storage.
//   - instr_valid rises in the cycle after the response, giving a minimum of 2 cycles from acceptance to instr_valid.
//   - Pop occurs on instr_valid & instr_ready.
//   - Push and pop in the same cycle are legal at any occupancy, including full.
//   - The buffer never overflows, because the credit rule reserves a slot for every outstanding request.
// - Redirect (takes precedence over push/pop/issue in its cycle):
//   - Buffer flushed: occupancy=0. instr_valid is 0 from the next cycle.
//   - drop = outstanding after this cycle's accept/response updates.
//   - fetch_pc = resp_pc = {redirect_pc[31:2], 2'b00}; misaligned low bits are silently cleared.
//   - A pop handshaking in the redirect cycle counts as consumed.
//   - A response arriving in the redirect cycle is discarded.
//   - An unaccepted request is withdrawn; its address is not re-issued.
//   - Back-to-back redirects: the last one wins, and drop accumulates correctly.
// - imem_resp_valid with outstanding == 0 is a protocol violation. It is ignored, and a simulation-only assertion fires.
// STRUCTURE
// - cpu_pkg: XLEN=32, ILEN=32, DEFAULT_RESET_PC, and the opcode constants shared with decode.
// - Sub-module fetch_fifo #(DEPTH, WIDTH=64): storage, read/write pointers with wrap, occupancy, flush input.
// - The top level holds fetch_pc, resp_pc, the outstanding/drop counters, and the credit logic.
// TESTING
// - Reset; memory always ready, 1-cycle latency; ROM[0]=32'h005303b3, ROM[1]=32'h40848533, ROM[2]=32'h00160693; instr_ready=1
//   -> req addrs 0x0,0x4,0x8; instr/instr_pc = 005303b3/0x0, 40848533/0x4, 00160693/0x8 on consecutive cycles.
// - instr_ready=0 after reset
//   -> exactly 2 requests (0x0,0x4); imem_req_valid then 0; buffer holds 2.
//   -> Raise ready -> pops 0x0,0x4; next request is 0x8.
// - imem_req_ready low for 3 cycles with a request pending at 0x8
//   -> imem_req_valid=1 and addr=0x8 stable for all 3 cycles; a single accept follows.
// - Two requests in flight (0x8,0xC); redirect_pc=0x40; responses arrive 1 and 2 cycles later
//   -> both discarded; first instr_valid shows instr_pc=0x40.
// - redirect_valid and reset in the same cycle -> reset wins: next request addr = RESET_PC.
// - Redirect to 0x43 -> request addr 0x40. Redirect to 0xFFFF_FFFC -> following request addr 0x0.

Source files
------------

// File: rtl/instruction_fetch_pkg.sv
// Shared CPU constants for the fetch stage and decode: word sizes, reset PC,
// opcode encodings and the fetch buffer entry layout.
package instruction_fetch_pkg;

    localparam int XLEN = 32;
    localparam int ILEN = 32;

    localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [ILEN-1:0] word;
    } fetch_entry_t;

    // Fetch only ever addresses whole words.
    function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] addr);
        return {addr[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/instruction_fetch_if.sv
// Fetch-stage signal bundle: instruction memory request/response, redirect
// from execute, and the instruction handshake towards decode.
interface instruction_fetch_if;
    import instruction_fetch_pkg::*;

    logic            imem_req_valid;
    logic            imem_req_ready;
    logic [XLEN-1:0] imem_req_addr;
    logic            imem_resp_valid;
    logic [ILEN-1:0] imem_resp_data;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic            instr_valid;
    logic            instr_ready;
    logic [ILEN-1:0] instr;
    logic [XLEN-1:0] instr_pc;

    modport master (
        output imem_req_valid, imem_req_addr, instr_valid, instr, instr_pc,
        input  imem_req_ready, imem_resp_valid, imem_resp_data,
               redirect_valid, redirect_pc, instr_ready
    );

    modport slave (
        input  imem_req_valid, imem_req_addr, instr_valid, instr, instr_pc,
        output imem_req_ready, imem_resp_valid, imem_resp_data,
               redirect_valid, redirect_pc, instr_ready
    );

endinterface

// File: rtl/instruction_fetch_fifo.sv
// Fetch buffer: power-of-2 circular queue with registered storage, occupancy
// count and a flush that empties it in one cycle.
module fetch_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 64
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic                     valid,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_pop;

    assign do_pop = pop && valid;
    assign valid  = (count != '0);
    assign rdata  = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            // Pointers wrap naturally because DEPTH is a power of two.
            if (push) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (do_pop) rd_ptr <= rd_ptr + AW'(1);
            count <= count + (AW+1)'(push) - (AW+1)'(do_pop);
        end
    end

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: credit-limited in-order requests to a variable-latency
// instruction memory, PC-tagged buffering, and redirect with response drop.
module instruction_fetch
    import instruction_fetch_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int              DEPTH    = 2
) (
    input  logic                clk,
    input  logic                reset,
    instruction_fetch_if.master bus
);

    localparam int CW = $clog2(DEPTH);

    logic [XLEN-1:0] fetch_pc;
    logic [XLEN-1:0] resp_pc;
    logic [CW:0]     outstanding;
    logic [CW:0]     outstanding_nx;
    logic [CW:0]     drop;
    logic [CW:0]     occupancy;
    logic [CW+1:0]   credit_used;
    logic            accept;
    logic            resp_live;
    logic            push;
    logic            pop;
    logic            head_valid;
    fetch_entry_t    head;
    fetch_entry_t    entry_in;

    // Every in-flight request owns a buffer slot, so a response can always be pushed.
    assign credit_used        = {1'b0, outstanding} + {1'b0, occupancy};
    assign bus.imem_req_valid = !reset && !bus.redirect_valid
                                && (credit_used < (CW+2)'(DEPTH));
    assign bus.imem_req_addr  = fetch_pc;

    assign accept    = bus.imem_req_valid && bus.imem_req_ready;
    assign resp_live = bus.imem_resp_valid && (outstanding != '0);
    assign push      = resp_live && (drop == '0) && !bus.redirect_valid;
    assign pop       = head_valid && bus.instr_ready;

    assign outstanding_nx = outstanding + (CW+1)'(accept) - (CW+1)'(resp_live);

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc    <= RESET_PC;
            resp_pc     <= RESET_PC;
            outstanding <= '0;
            drop        <= '0;
        end else begin
            outstanding <= outstanding_nx;
            if (bus.redirect_valid) begin
                // Everything still in flight belongs to the old path.
                fetch_pc <= align_word(bus.redirect_pc);
                resp_pc  <= align_word(bus.redirect_pc);
                drop     <= outstanding_nx;
            end else begin
                if (accept)                     fetch_pc <= fetch_pc + 32'd4;
                if (push)                       resp_pc  <= resp_pc + 32'd4;
                if (resp_live && drop != '0)    drop     <= drop - (CW+1)'(1);
            end
        end
    end

    assign entry_in.pc   = resp_pc;
    assign entry_in.word = bus.imem_resp_data;

    fetch_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (XLEN + ILEN)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .flush (bus.redirect_valid),
        .push  (push),
        .wdata (entry_in),
        .pop   (pop),
        .rdata (head),
        .valid (head_valid),
        .count (occupancy)
    );

    assign bus.instr_valid = head_valid;
    assign bus.instr       = head.word;
    assign bus.instr_pc    = head.pc;

    // Simulation-only check: a response with nothing outstanding is ignored above.
    always @(posedge clk) begin
        if (!reset && bus.imem_resp_valid) assert (outstanding != '0);
    end

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: in-order memory model with 1-cycle
// latency and a response hold, checked against hand-computed values.
module tb_instruction_fetch;
    import instruction_fetch_pkg::*;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    instruction_fetch_if bus ();

    instruction_fetch #(.RESET_PC(32'h0000_0000), .DEPTH(2)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int          passes = 0;
    int          total  = 0;
    logic [31:0] q_addr[$];
    logic [31:0] acc_log[$];
    logic        hold;
    int          w;

    function automatic logic [31:0] rom(input logic [31:0] a);
        case (a)
            32'h0:   return 32'h005303b3;
            32'h4:   return 32'h40848533;
            32'h8:   return 32'h00160693;
            default: return a ^ 32'hA5A5_0000;
        endcase
    endfunction

    function automatic logic [31:0] get_acc(input int i);
        if (i < acc_log.size()) return acc_log[i];
        return 32'hDEAD_BEEF;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic drive_resp();
        if (!hold && q_addr.size() != 0) begin
            bus.imem_resp_valid = 1'b1;
            bus.imem_resp_data  = rom(q_addr[0]);
        end else begin
            bus.imem_resp_valid = 1'b0;
            bus.imem_resp_data  = 32'h0;
        end
    endtask

    // One clock: sample handshakes before the edge, update the memory model after it.
    task automatic tick();
        logic        acc;
        logic        rsp;
        logic [31:0] a;
        #1;
        acc = bus.imem_req_valid && bus.imem_req_ready;
        a   = bus.imem_req_addr;
        rsp = bus.imem_resp_valid;
        @(posedge clk);
        #1;
        if (reset) begin
            q_addr.delete();
        end else begin
            if (rsp) void'(q_addr.pop_front());
            if (acc) begin
                q_addr.push_back(a);
                acc_log.push_back(a);
            end
        end
        drive_resp();
        #1;
    endtask

    // Waits (bounded) for a head entry, checks it, then consumes it with one clock.
    task automatic wait_instr(input string tag, input logic [31:0] pc,
                              input logic [31:0] word, output int waited);
        waited = 0;
        while (!bus.instr_valid && waited < 20) begin
            tick();
            waited++;
        end
        chk({tag, "_valid"}, 32'(bus.instr_valid), 32'd1);
        chk({tag, "_pc"},    bus.instr_pc, pc);
        chk({tag, "_instr"}, bus.instr,    word);
        tick();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        bus.redirect_valid = 1'b0;
        hold = 1'b0;
        tick();
        tick();
        acc_log.delete();
        reset = 1'b0;
        #1;
    endtask

    initial begin
        reset = 1'b1;
        hold  = 1'b0;
        bus.imem_req_ready  = 1'b1;
        bus.imem_resp_valid = 1'b0;
        bus.imem_resp_data  = 32'h0;
        bus.redirect_valid  = 1'b0;
        bus.redirect_pc     = 32'h0;
        bus.instr_ready     = 1'b1;

        // Reset state
        tick();
        tick();
        chk("rst_req_valid",   32'(bus.imem_req_valid), 32'd0);
        chk("rst_instr_valid", 32'(bus.instr_valid),    32'd0);
        chk("rst_instr",       bus.instr,               32'h0);
        chk("rst_instr_pc",    bus.instr_pc,            32'h0);
        acc_log.delete();
        reset = 1'b0;
        #1;
        chk("first_req_valid", 32'(bus.imem_req_valid), 32'd1);
        chk("first_req_addr",  bus.imem_req_addr,       32'h0);

        // Streaming with decode always ready
        wait_instr("t1_i0", 32'h0, 32'h005303b3, w);
        chk("t1_min_latency", w, 2);
        wait_instr("t1_i1", 32'h4, 32'h40848533, w);
        chk("t1_back_to_back", w, 0);
        wait_instr("t1_i2", 32'h8, 32'h00160693, w);
        chk("t1_acc0", get_acc(0), 32'h0);
        chk("t1_acc1", get_acc(1), 32'h4);
        chk("t1_acc2", get_acc(2), 32'h8);

        // Decode stalled: credits stop issue after two requests
        bus.instr_ready = 1'b0;
        do_reset();
        for (int i = 0; i < 8; i++) tick();
        chk("t2_acc_count", acc_log.size(), 2);
        chk("t2_acc0", get_acc(0), 32'h0);
        chk("t2_acc1", get_acc(1), 32'h4);
        chk("t2_req_blocked", 32'(bus.imem_req_valid), 32'd0);
        chk("t2_head_pc", bus.instr_pc, 32'h0);

        // Drain the two buffered words while memory refuses the next request
        bus.imem_req_ready = 1'b0;
        bus.instr_ready    = 1'b1;
        wait_instr("t2_pop0", 32'h0, 32'h005303b3, w);
        chk("t2_pop0_wait", w, 0);
        wait_instr("t2_pop1", 32'h4, 32'h40848533, w);
        chk("t2_pop1_wait", w, 0);
        for (int i = 0; i < 3; i++) begin
            chk("t3_hold_valid", 32'(bus.imem_req_valid), 32'd1);
            chk("t3_hold_addr",  bus.imem_req_addr,       32'h8);
            tick();
        end
        chk("t3_no_accept_while_low", acc_log.size(), 2);
        hold = 1'b1;
        bus.imem_req_ready = 1'b1;
        tick();
        chk("t3_single_accept", acc_log.size(), 3);
        chk("t3_accept_addr", get_acc(2), 32'h8);
        chk("t4_second_req", bus.imem_req_addr, 32'hC);
        tick();
        chk("t4_acc_c", get_acc(3), 32'hC);
        chk("t4_credits_full", 32'(bus.imem_req_valid), 32'd0);

        // Redirect with two responses still in flight
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h40;
        #1;
        chk("t4_redirect_withdraw", 32'(bus.imem_req_valid), 32'd0);
        tick();
        bus.redirect_valid = 1'b0;
        hold = 1'b0;
        drive_resp();
        #1;
        chk("t4_flushed", 32'(bus.instr_valid), 32'd0);
        wait_instr("t4_first", 32'h40, 32'hA5A5_0040, w);
        chk("t4_acc_40", get_acc(4), 32'h40);

        // Reset beats a simultaneous redirect
        reset = 1'b1;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h80;
        tick();
        reset = 1'b0;
        bus.redirect_valid = 1'b0;
        acc_log.delete();
        #1;
        chk("t5_req_valid", 32'(bus.imem_req_valid), 32'd1);
        chk("t5_req_addr",  bus.imem_req_addr,       32'h0);

        // Misaligned redirect and address wrap
        bus.imem_req_ready = 1'b0;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h43;
        tick();
        bus.redirect_valid = 1'b0;
        #1;
        chk("t6_align_valid", 32'(bus.imem_req_valid), 32'd1);
        chk("t6_align_addr",  bus.imem_req_addr,       32'h40);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'hFFFF_FFFC;
        tick();
        bus.redirect_valid = 1'b0;
        #1;
        chk("t6_top_addr", bus.imem_req_addr, 32'hFFFF_FFFC);
        bus.imem_req_ready = 1'b1;
        tick();
        chk("t6_wrap_valid", 32'(bus.imem_req_valid), 32'd1);
        chk("t6_wrap_addr",  bus.imem_req_addr,       32'h0);
        chk("t6_acc_top", get_acc(0), 32'hFFFF_FFFC);
        wait_instr("t6_top", 32'hFFFF_FFFC, 32'h5A5A_FFFC, w);
        wait_instr("t6_zero", 32'h0, 32'h005303b3, w);

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
